// File: rtl/apb_rx_pkg.sv
// Shared types and constants for the oversampled serial receiver.
// State encodings, frame lengths (last bit index = stop bit) and the default oversample ratio.
package apb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int         OSR_DEF     = 16;
    localparam logic [3:0] LAST_IDX_8  = 4'd9;
    localparam logic [3:0] LAST_IDX_10 = 4'd11;

    // Index of the stop bit for the latched frame format.
    function automatic logic [3:0] last_idx(input logic mode_10);
        return mode_10 ? LAST_IDX_10 : LAST_IDX_8;
    endfunction

endpackage

// File: rtl/apb_rx_seq_if.sv
// Control, serial line and holding-register signals of the receiver.
// master drives select/enable/mode/ticks/line/ack; slave is the receiver.
interface apb_rx_seq_if;

    logic       sel;
    logic       rx_en;
    logic       mode;
    logic       baud_clk;
    logic       rx_in;
    logic       rd_ack;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
    logic [3:0] bit_cnt;

    modport master (
        output sel, rx_en, mode, baud_clk, rx_in, rd_ack,
        input  rx_data, rx_valid, frame_err, overrun, rx_busy, bit_cnt
    );

    modport slave (
        input  sel, rx_en, mode, baud_clk, rx_in, rd_ack,
        output rx_data, rx_valid, frame_err, overrun, rx_busy, bit_cnt
    );

endinterface

// File: rtl/apb_rx_sync.sv
// Line synchroniser with falling-edge detect; rx_s lags rx_in by SYNC_STAGES clk, rx_fall is combinational on rx_s.
// No backpressure. Edges are only reported once both compared samples were taken after reset release.
module apb_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '1;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= rx_in;
            fill_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            for (int i = 1; i <= SYNC_STAGES; i++) fill_q[i] <= fill_q[i-1];
            prev_q <= rx_s;
        end
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    // A line already low at release must not look like a fresh start bit.
    assign rx_fall = fill_q[SYNC_STAGES] & prev_q & ~rx_s;

endmodule

// File: rtl/apb_rx_seq.sv
// Serial receiver: start/data/stop sampling at OSR ticks per bit into one holding register.
// rx_valid rises 1 clk after the stop sample; no backpressure, a full register drops the frame and pulses overrun.
module apb_rx_seq
    import apb_rx_pkg::*;
#(
    parameter int OSR         = OSR_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    apb_rx_seq_if.slave bus
);

    localparam int            TW     = $clog2(OSR);
    localparam logic [TW-1:0] T_HALF = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OSR - 1);

    rx_state_t     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic          mode_q, mode_d;
    logic          ld_q, ld_d;
    logic          stop_q, stop_d;
    logic [9:0]    rx_data_q;
    logic          rx_valid_q, frame_err_q, overrun_q;
    logic          rx_s, rx_fall, active, tick;

    assign active = bus.sel & bus.rx_en;
    assign tick   = bus.baud_clk;

    apb_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .rx_in   (bus.rx_in),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            mode_q    <= 1'b0;
            ld_q      <= 1'b0;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            ld_q      <= ld_d;
            stop_q    <= stop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        mode_d    = mode_q;
        ld_d      = 1'b0;
        stop_d    = stop_q;
        if (!active) begin
            state_d   = ST_IDLE;
            tcnt_d    = '0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tcnt_d    = '0;
                    bit_cnt_d = '0;
                    if (rx_fall) begin
                        state_d = ST_START;
                        mode_d  = bus.mode;
                    end
                end
                ST_START: if (tick) begin
                    if (tcnt_q == T_HALF) begin
                        tcnt_d = '0;
                        // A high line at mid start bit was only a glitch.
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                ST_DATA: if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d    = '0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        for (int i = 0; i < 10; i++)
                            if (bit_cnt_q == 4'(i + 1)) shift_d[i] = rx_s;
                        if (bit_cnt_q == last_idx(mode_q) - 4'd1) state_d = ST_STOP;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                ST_STOP: if (tick) begin
                    if (tcnt_q == T_FULL) begin
                        tcnt_d    = '0;
                        bit_cnt_d = '0;
                        stop_d    = rx_s;
                        ld_d      = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rx_busy   = (state_q != ST_IDLE);
        bus.bit_cnt   = bit_cnt_q;
        bus.rx_data   = rx_data_q;
        bus.rx_valid  = rx_valid_q;
        bus.frame_err = frame_err_q;
        bus.overrun   = overrun_q;
    end

    // A load in the same clk as rd_ack replaces the old frame instead of overrunning.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (ld_q) begin
                if (!rx_valid_q || bus.rd_ack) begin
                    rx_data_q   <= mode_q ? shift_q : {2'b00, shift_q[7:0]};
                    frame_err_q <= ~stop_q;
                    rx_valid_q  <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rd_ack) begin
                rx_valid_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_rx_seq.sv
// Directed bench for apb_rx_seq: frame scheduler model plus per-cycle output compare.
module tb_apb_rx_seq;

    localparam int OSR = 16;
    localparam int SS  = 2;
    localparam int SD  = SS + 1;   // edges from rx_in falling to START entry

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    apb_rx_seq_if bus();

    apb_rx_seq #(.OSR(OSR), .SYNC_STAGES(SS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct { int s; int e; int n; } win_t;          // busy after edges s..e-1
    typedef struct { int e; logic [9:0] d; logic fe; } ld_t;  // holding load at edge e

    win_t wins[$];
    ld_t  lds[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    logic       m_v = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [9:0] m_d = '0;
    int   rise_e = -1, ov_cnt = 0, busy_cnt = 0, bc_max = 0, bc_steps = 0, prev_bc = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic ack_e, rst_e, eb, hit;
        int   ebc;
        ld_t  l;
        ack_e = bus.rd_ack;
        rst_e = rstn;
        cyc++;
        #1;
        m_ov = 1'b0;
        hit  = 1'b0;
        if (lds.size() > 0 && lds[0].e == cyc) begin
            l   = lds.pop_front();
            hit = 1'b1;
        end
        if (!rst_e) begin
            m_v = 1'b0; m_d = '0; m_fe = 1'b0;
        end else if (hit) begin
            if (!m_v || ack_e) begin
                m_d = l.d; m_fe = l.fe; m_v = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end else if (m_v && ack_e) begin
            m_v = 1'b0; m_fe = 1'b0;
        end
        eb  = 1'b0;
        ebc = 0;
        foreach (wins[i]) begin
            if (cyc >= wins[i].s && cyc < wins[i].e) begin
                eb  = 1'b1;
                ebc = (cyc < wins[i].s + OSR/2) ? 0 : 1 + (cyc - wins[i].s - OSR/2) / OSR;
                if (ebc > wins[i].n + 1) ebc = wins[i].n + 1;
            end
        end
        chk("rx_valid",  bus.rx_valid,  m_v);
        chk("rx_data",   bus.rx_data,   m_d);
        chk("frame_err", bus.frame_err, m_fe);
        chk("overrun",   bus.overrun,   m_ov);
        chk("rx_busy",   bus.rx_busy,   eb);
        chk("bit_cnt",   bus.bit_cnt,   ebc);
        if (bus.rx_valid === 1'b1 && prev_v !== 1'b1) rise_e = cyc;
        prev_v = bus.rx_valid;
        if (bus.overrun === 1'b1) ov_cnt++;
        if (bus.rx_busy === 1'b1) busy_cnt++;
        if (int'(bus.bit_cnt) == prev_bc + 1) bc_steps++;
        if (int'(bus.bit_cnt) > bc_max) bc_max = int'(bus.bit_cnt);
        prev_bc = int'(bus.bit_cnt);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        idle(2);
    endtask

    // Called at a negedge. abort_kind: 0 none, 1 drop rx_en, 2 pulse rstn, at cycle k+abort_at.
    task automatic send_frame(input logic [9:0] d, input bit m10, input bit stop_v, input bit tog,
                              input int abort_at, input int abort_kind);
        int   k, n, e_end;
        logic bv;
        k = cyc;
        n = m10 ? 10 : 8;
        if (abort_kind == 0) e_end = k + SD + OSR/2 + OSR * (n + 1);
        else                 e_end = k + abort_at + 1;
        wins.push_back('{k + SD, e_end, n});
        if (abort_kind == 0)
            lds.push_back('{e_end + 1, (m10 ? d : {2'b00, d[7:0]}), logic'(~stop_v)});
        for (int j = 0; j <= n + 1; j++) begin
            bv = (j == 0) ? 1'b0 : (j == n + 1) ? logic'(stop_v) : d[j-1];
            bus.rx_in = bv;
            if (tog && j >= 2) bus.mode = ~bus.mode;
            for (int c = 0; c < OSR; c++) begin
                if (abort_kind != 0 && cyc == k + abort_at) begin
                    bus.rx_in = 1'b1;
                    if (abort_kind == 1) bus.rx_en = 1'b0;
                    else                 rstn = 1'b0;
                    idle(3);
                    bus.rx_en = 1'b1;
                    rstn      = 1'b1;
                    idle(6);
                    return;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic send_glitch(input int len);
        int k;
        k = cyc;
        wins.push_back('{k + SD, k + SD + OSR/2, 8});
        bus.rx_in = 1'b0;
        idle(len);
        bus.rx_in = 1'b1;
        idle(OSR * 2);
    endtask

    initial begin
        int k0;
        rstn = 1'b0;
        bus.sel = 1'b1; bus.rx_en = 1'b1; bus.mode = 1'b0;
        bus.baud_clk = 1'b1; bus.rx_in = 1'b1; bus.rd_ack = 1'b0;
        idle(3);
        chk("reset_valid", bus.rx_valid, 0);
        chk("reset_data", bus.rx_data, 0);
        chk("reset_busy", bus.rx_busy, 0);
        chk("reset_bitcnt", bus.bit_cnt, 0);
        rstn = 1'b1;
        idle(6);

        // 8-bit frame, latency pinned to 16*9+8+1 clk after START entry
        rise_e = -1;
        k0 = cyc;
        send_frame(10'h0A5, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(4);
        chk("t1_data", bus.rx_data, 10'h0A5);
        chk("t1_valid", bus.rx_valid, 1);
        chk("t1_ferr", bus.frame_err, 0);
        chk("t1_latency", rise_e, k0 + SD + 153);
        ack_pulse();
        chk("t1_ack_valid", bus.rx_valid, 0);
        chk("t1_ack_hold", bus.rx_data, 10'h0A5);

        // 10-bit frame with mode toggling mid-frame
        bc_max = 0; bc_steps = 0;
        bus.mode = 1'b1;
        send_frame(10'h2C3, 1'b1, 1'b1, 1'b1, 0, 0);
        bus.mode = 1'b0;
        idle(4);
        chk("t2_data", bus.rx_data, 10'h2C3);
        chk("t2_valid", bus.rx_valid, 1);
        chk("t2_bitcnt_max", bc_max, 11);
        chk("t2_bitcnt_steps", bc_steps, 11);
        ack_pulse();

        // start-bit glitch
        busy_cnt = 0;
        send_glitch(5);
        chk("t3_valid", bus.rx_valid, 0);
        chk("t3_busy_clks", busy_cnt, 8);

        // overrun, then load coincident with rd_ack
        ov_cnt = 0;
        send_frame(10'h011, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(4);
        send_frame(10'h022, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(4);
        chk("t4_kept_data", bus.rx_data, 10'h011);
        chk("t4_kept_valid", bus.rx_valid, 1);
        chk("t4_overrun_cnt", ov_cnt, 1);
        ack_pulse();
        ov_cnt = 0;
        send_frame(10'h011, 1'b0, 1'b1, 1'b0, 0, 0);
        idle(4);
        k0 = cyc;
        fork
            send_frame(10'h022, 1'b0, 1'b1, 1'b0, 0, 0);
            begin
                while (cyc != k0 + SD + 153 - 1) @(negedge clk);
                bus.rd_ack = 1'b1;
                @(negedge clk);
                bus.rd_ack = 1'b0;
            end
        join
        idle(4);
        chk("t4_ack_data", bus.rx_data, 10'h022);
        chk("t4_ack_valid", bus.rx_valid, 1);
        chk("t4_ack_overrun_cnt", ov_cnt, 0);
        ack_pulse();

        // framing error with the line left low
        send_frame(10'h00F, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(4);
        chk("t5_ferr", bus.frame_err, 1);
        chk("t5_data", bus.rx_data, 10'h00F);
        busy_cnt = 0;
        idle(80);
        chk("t5_no_restart", busy_cnt, 0);
        bus.rx_in = 1'b1;
        idle(10);

        // aborts at data bit 4: rx_en drop keeps holding, reset clears it
        send_frame(10'h0B4, 1'b0, 1'b1, 1'b0, OSR * 4 + 6, 1);
        chk("t6_en_data", bus.rx_data, 10'h00F);
        chk("t6_en_valid", bus.rx_valid, 1);
        chk("t6_en_busy", bus.rx_busy, 0);
        send_frame(10'h0B4, 1'b0, 1'b1, 1'b0, OSR * 4 + 6, 2);
        chk("t6_rst_data", bus.rx_data, 0);
        chk("t6_rst_valid", bus.rx_valid, 0);
        chk("t6_rst_busy", bus.rx_busy, 0);
        chk("t6_rst_bitcnt", bus.bit_cnt, 0);
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_rx_seq.md
APB_RX_SEQ -- requirements
Module: apb_rx_seq

Interface
REQ-001 SHALL have parameter OSR, default 16: baud_clk ticks per bit period; legal values are even numbers 4..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: rx_in synchroniser depth.
REQ-003 SHALL have port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port sel, input, 1: peripheral select.
REQ-006 SHALL have port rx_en, input, 1: receiver enable; the receiver is active only when sel and rx_en are both 1.
REQ-007 SHALL have port mode, input, 1: 0 = 8 data bits, 1 = 10 data bits.
REQ-008 SHALL have port baud_clk, input, 1: oversample tick; one tick per clk cycle in which it is high.
REQ-009 SHALL have port rx_in, input, 1: asynchronous serial line, idle high.
REQ-010 SHALL have port rd_ack, input, 1: the consumer has read rx_data.
REQ-011 SHALL have port rx_data, output, 10: holding register, LSB = first data bit received.
REQ-012 SHALL have port rx_valid, output, 1: the holding register is full.
REQ-013 SHALL have port frame_err, output, 1: latched with rx_data; set when the stop bit was sampled 0.
REQ-014 SHALL have port overrun, output, 1: one-clk pulse when a completed frame is dropped.
REQ-015 SHALL have port rx_busy, output, 1: 1 whenever the FSM is not in IDLE.
REQ-016 SHALL have port bit_cnt, output, 4: index of the current frame bit; start = 0, data = 1..N, stop = N+1.

Function
REQ-017 SHALL pass rx_in through a SYNC_STAGES-flop synchroniser; its flops reset to 1. Falling-edge detect SHALL compare against the previous synchronised value.
REQ-018 SHALL implement the FSM states IDLE, START, DATA and STOP, with a tick counter tcnt and a bit counter bit_cnt.
REQ-019 IDLE: on a synchronised falling edge while active, go to START with tcnt = 0; mode SHALL be latched into mode_q at this point, and mid-frame changes to mode SHALL be ignored.
REQ-020 START: tcnt SHALL count ticks; at the tick where tcnt = OSR/2-1, sample the line. If the sample is 0, go to DATA with tcnt = 0 and bit_cnt = 1. If the sample is 1, treat it as a glitch and return to IDLE with no outputs changed.
REQ-021 DATA: sample once every OSR ticks (tick where tcnt = OSR-1), store the sample into shift bit bit_cnt-1, and increment bit_cnt. After bit N is sampled (N = 8 if mode_q = 0, else 10), go to STOP.
REQ-022 STOP: sample after OSR ticks, load the holding register the following clk, and return to IDLE.
REQ-023 Ticks SHALL only advance tcnt; clk cycles with baud_clk = 0 SHALL hold all counters.
REQ-024 Load: rx_data = shift register with bits [9:8] forced to 0 when mode_q = 0; frame_err = NOT(stop sample); rx_valid = 1. Latency from the stop-sample tick to rx_valid = 1 SHALL be exactly 1 clk.
REQ-025 rd_ack while rx_valid = 1 SHALL clear rx_valid and frame_err on the next clk; rx_data SHALL hold its value.
REQ-026 If a load occurs while rx_valid = 1 and rd_ack = 0, the new frame SHALL be discarded, the holding register left unchanged, and overrun pulsed for 1 clk.
REQ-027 If a load and rd_ack occur in the same clk, the load SHALL win: new data is stored, rx_valid stays 1, and no overrun is signalled.
REQ-028 If the line stays low after a framing error, no new frame SHALL start until the line returns high and falls again.
REQ-029 If sel or rx_en drops mid-frame, the FSM SHALL go to IDLE on the next clk, the partial frame SHALL be discarded, and the holding register SHALL be untouched.
REQ-030 tcnt SHALL be wide enough for OSR-1 and SHALL wrap to 0 at each sample point; bit_cnt SHALL never exceed 11.

Reset
REQ-031 While rstn = 0 at a clk edge: FSM = IDLE, tcnt = 0, bit_cnt = 0, shift register = 0, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, rx_busy = 0, and synchroniser flops = 1.
REQ-032 Reset mid-frame SHALL abandon the frame; the first edge after release SHALL be treated as a new start candidate only if the line falls after release.

Structure
REQ-033 Package apb_rx_pkg SHALL hold the FSM state encodings, the frame lengths (8-bit: last index 9; 10-bit: last index 11) and the OSR default.
REQ-034 Sub-module apb_rx_sync SHALL contain the synchroniser and falling-edge detector; all other logic SHALL reside in apb_rx_seq.

Verification
REQ-035 Bench configuration: OSR = 16 and baud_clk tied high. Test 1: mode = 0, send 0xA5 with stop = 1 -> rx_data = 0x0A5, rx_valid = 1 exactly 1 clk after the stop sample (clk 16*9+8+1 after the falling edge, synchroniser delay excluded), frame_err = 0.
REQ-036 Test 2: mode = 1, send 0x2C3 -> rx_data = 0x2C3, bit_cnt sequence 0 to 11, rx_valid = 1; toggling mode mid-frame has no effect on the result.
REQ-037 Test 3: 5-clk low glitch on rx_in -> START returns to IDLE, rx_valid remains 0, rx_busy drops by clk 10.
REQ-038 Test 4: two frames 0x11 then 0x22 with no rd_ack -> rx_data = 0x011 retained and overrun pulses once; a repeat with rd_ack coincident with the second load -> rx_data = 0x022, rx_valid = 1, no overrun.
REQ-039 Test 5: frame 0x0F with stop = 0 -> frame_err = 1 and rx_data = 0x00F; the line held low does not start a new frame.
REQ-040 Test 6: rx_en deasserted at data bit 4, then rstn pulsed mid-frame -> FSM in IDLE next clk, holding register unchanged (rx_en case) or zeroed (rstn case).
